// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, alu_op codes and FSM states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b101;
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;

    // S_TRAP is only reachable when the illegal-opcode trap is built in.
    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
    } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; expired rises once LIMIT waiting cycles have elapsed.
module mem_wait_timer #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with bounded memory wait and timeout pulse.
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to add illegal_op and a sticky TRAP state for undefined opcodes.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic       mem_timeout
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    state_e state, next_state;
    logic   timer_clr, timer_en, timer_expired;

    mem_wait_timer #(.LIMIT(8'(MEM_WAIT_MAX))) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RESET;
        else     state <= next_state;
    end

    // The timer only runs while a memory state is still waiting; any other cycle clears it,
    // so it is zero on every entry to FETCH, MEMRD or MEMWR.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        next_state    = state;
        timer_clr     = 1'b1;
        timer_en      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        alu_op        = ALUOP_ADD;
        mem_timeout   = 1'b0;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        illegal_op    = 1'b0;
`endif
        unique case (state)
            S_RESET: next_state = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (timer_expired) begin
                    mem_timeout = 1'b1;
                    next_state  = S_FETCH;
                end else if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end else begin
                    timer_clr = 1'b0;
                    timer_en  = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDIEX;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                    default:      next_state = S_TRAP;
`else
                    default:      next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (timer_expired) begin
                    mem_timeout = 1'b1;
                    next_state  = S_FETCH;
                end else if (mem_ready) begin
                    next_state = S_MEMWB;
                end else begin
                    timer_clr = 1'b0;
                    timer_en  = 1'b1;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                iord = 1'b1;
                if (timer_expired) begin
                    mem_timeout = 1'b1;
                    next_state  = S_FETCH;
                end else begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        next_state = S_FETCH;
                    end else begin
                        timer_clr = 1'b0;
                        timer_en  = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_RTYPE;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                next_state    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                next_state = S_FETCH;
            end
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: illegal_op = 1'b1;
`endif
            default: next_state = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed table, corner sequences, random vs step-queue model.
module tb_multicycle_control;

    localparam int MAXW = 4;

    // Packed expected-output layout, MSB first:
    // pc_write pc_write_cond iord mem_read mem_write ir_write mem_to_reg reg_dst reg_write
    // alu_src_a alu_src_b[1:0] pc_src[1:0] alu_op[2:0] mem_timeout
    localparam logic [17:0] PCW    = 18'h20000;
    localparam logic [17:0] PCWC   = 18'h10000;
    localparam logic [17:0] IORD   = 18'h08000;
    localparam logic [17:0] MR     = 18'h04000;
    localparam logic [17:0] MW     = 18'h02000;
    localparam logic [17:0] IRW    = 18'h01000;
    localparam logic [17:0] M2R    = 18'h00800;
    localparam logic [17:0] RDST   = 18'h00400;
    localparam logic [17:0] RW     = 18'h00200;
    localparam logic [17:0] SRCA   = 18'h00100;
    localparam logic [17:0] B_4    = 18'h00040;
    localparam logic [17:0] B_IMM  = 18'h00080;
    localparam logic [17:0] B_SH   = 18'h000C0;
    localparam logic [17:0] PS_OUT = 18'h00010;
    localparam logic [17:0] PS_J   = 18'h00020;
    localparam logic [17:0] OP_SUB = 18'h0000A;
    localparam logic [17:0] OP_R   = 18'h0000E;
    localparam logic [17:0] TO     = 18'h00001;
    localparam logic [17:0] F_RDY  = PCW | MR | IRW | B_4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, mem_timeout;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src),
        .alu_op        (alu_op),
        .mem_timeout   (mem_timeout)
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_op    (illegal_op)
`endif
    );

    function automatic logic [17:0] dut_vec();
        return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, alu_op, mem_timeout};
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the instruction is a queue of remaining steps; memory steps track waited cycles.
    typedef enum {K_RST, K_FETCH, K_DEC, K_MADR, K_MRD, K_MWB, K_MWR,
                  K_EXE, K_AWB, K_IEX, K_IWB, K_BR, K_J, K_TRAP} kind_e;
    kind_e steps[$];
    int    m_wait;

    task automatic set_steps(input kind_e a, input kind_e b, input kind_e c, input int n);
        steps.delete();
        if (n > 0) steps.push_back(a);
        if (n > 1) steps.push_back(b);
        if (n > 2) steps.push_back(c);
    endtask

    function automatic bit is_mem(kind_e k);
        return k == K_FETCH || k == K_MRD || k == K_MWR;
    endfunction

    function automatic logic [17:0] model_exp(input logic rdy);
        kind_e k = steps[0];
        bit    to = is_mem(k) && (m_wait == MAXW);
        case (k)
            K_FETCH: return MR | B_4 | (to ? TO : (rdy ? (PCW | IRW) : 18'h0));
            K_DEC:   return B_SH;
            K_MADR:  return SRCA | B_IMM;
            K_MRD:   return IORD | MR | (to ? TO : 18'h0);
            K_MWB:   return RW | M2R;
            K_MWR:   return IORD | (to ? TO : MW);
            K_EXE:   return SRCA | OP_R;
            K_AWB:   return RW | RDST;
            K_IEX:   return SRCA | B_IMM;
            K_IWB:   return RW;
            K_BR:    return SRCA | OP_SUB | PCWC | PS_OUT;
            K_J:     return PCW | PS_J;
            default: return 18'h0;
        endcase
    endfunction

    task automatic model_advance(input logic [5:0] op, input logic rdy);
        kind_e k = steps[0];
        if (is_mem(k)) begin
            if (m_wait == MAXW) begin
                set_steps(K_FETCH, K_FETCH, K_FETCH, 1);
                m_wait = 0;
            end else if (!rdy) begin
                m_wait++;
            end else begin
                m_wait = 0;
                if (k == K_FETCH) set_steps(K_DEC, K_DEC, K_DEC, 1);
                else void'(steps.pop_front());
            end
        end else begin
            m_wait = 0;
            case (k)
                K_RST: set_steps(K_FETCH, K_FETCH, K_FETCH, 1);
                K_DEC: begin
                    case (op)
                        6'b000000: set_steps(K_EXE, K_AWB, K_AWB, 2);
                        6'b100011: set_steps(K_MADR, K_MRD, K_MWB, 3);
                        6'b101011: set_steps(K_MADR, K_MWR, K_MWR, 2);
                        6'b000100: set_steps(K_BR, K_BR, K_BR, 1);
                        6'b000010: set_steps(K_J, K_J, K_J, 1);
                        6'b001000: set_steps(K_IEX, K_IWB, K_IWB, 2);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                        default:   set_steps(K_TRAP, K_TRAP, K_TRAP, 1);
`else
                        default:   set_steps(K_FETCH, K_FETCH, K_FETCH, 1);
`endif
                    endcase
                end
                K_TRAP: ;
                default: void'(steps.pop_front());
            endcase
        end
        if (steps.size() == 0) steps.push_back(K_FETCH);
    endtask

    // Entered and left at a falling edge: drive, sample 1 ns later, clock, advance the model.
    task automatic step(input logic [5:0] op, input logic rdy, input logic [17:0] exp,
                        input bit use_model, input string name);
        logic [17:0] e;
        opcode    = op;
        mem_ready = rdy;
        #1;
        e = use_model ? model_exp(rdy) : exp;
        check(name, dut_vec(), e);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        check({name, "_illegal"}, {17'd0, illegal_op}, {17'd0, steps[0] == K_TRAP});
`endif
        @(posedge clk);
        model_advance(op, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        #2 rst = 1'b1;
        #1 check(name, dut_vec(), 18'h0);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        check({name, "_illegal"}, {17'd0, illegal_op}, 18'h0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_steps(K_RST, K_RST, K_RST, 1);
        m_wait = 0;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [17:0] exp;
        string       name;
    } vec_t;

    initial begin
        vec_t       tbl[$];
        logic [5:0] ops[6];
        logic [5:0] cur_op;
        int         thr;
        logic       rdy;

        tbl.push_back('{6'h23, 1'b1, 18'h0,                     "lw_reset"});
        tbl.push_back('{6'h23, 1'b1, F_RDY,                     "lw_fetch"});
        tbl.push_back('{6'h23, 1'b1, B_SH,                      "lw_decode"});
        tbl.push_back('{6'h23, 1'b1, SRCA | B_IMM,              "lw_memadr"});
        tbl.push_back('{6'h23, 1'b1, IORD | MR,                 "lw_memrd"});
        tbl.push_back('{6'h23, 1'b1, RW | M2R,                  "lw_memwb"});
        tbl.push_back('{6'h00, 1'b1, F_RDY,                     "r_fetch"});
        tbl.push_back('{6'h00, 1'b1, B_SH,                      "r_decode"});
        tbl.push_back('{6'h00, 1'b1, SRCA | OP_R,               "r_exec"});
        tbl.push_back('{6'h00, 1'b1, RW | RDST,                 "r_aluwb"});
        tbl.push_back('{6'h04, 1'b1, F_RDY,                     "beq_fetch"});
        tbl.push_back('{6'h04, 1'b1, B_SH,                      "beq_decode"});
        tbl.push_back('{6'h04, 1'b1, SRCA | OP_SUB | PCWC | PS_OUT, "beq_branch"});
        tbl.push_back('{6'h02, 1'b1, F_RDY,                     "j_fetch"});
        tbl.push_back('{6'h02, 1'b1, B_SH,                      "j_decode"});
        tbl.push_back('{6'h02, 1'b1, PCW | PS_J,                "j_jump"});
        tbl.push_back('{6'h08, 1'b1, F_RDY,                     "addi_fetch"});
        tbl.push_back('{6'h08, 1'b1, B_SH,                      "addi_decode"});
        tbl.push_back('{6'h08, 1'b1, SRCA | B_IMM,              "addi_ex"});
        tbl.push_back('{6'h08, 1'b1, RW,                        "addi_wb"});

        @(negedge clk);
        do_reset("reset_state");
        foreach (tbl[i]) step(tbl[i].op, tbl[i].rdy, tbl[i].exp, 1'b0, tbl[i].name);

        // FETCH starved of mem_ready: four wait cycles, a timeout pulse, then a fresh FETCH.
        for (int i = 0; i < MAXW; i++) step(6'h2B, 1'b0, MR | B_4, 1'b0, "fetch_wait");
        step(6'h2B, 1'b0, MR | B_4 | TO, 1'b0, "fetch_timeout");
        step(6'h2B, 1'b1, F_RDY,         1'b0, "fetch_after_timeout");

        // sw with mem_ready low for three cycles keeps mem_write up for four.
        step(6'h2B, 1'b1, B_SH,         1'b0, "sw_decode");
        step(6'h2B, 1'b1, SRCA | B_IMM, 1'b0, "sw_memadr");
        for (int i = 0; i < 3; i++) step(6'h2B, 1'b0, IORD | MW, 1'b0, "sw_wait");
        step(6'h2B, 1'b1, IORD | MW, 1'b0, "sw_done");
        step(6'h3F, 1'b0, MR | B_4,  1'b0, "sw_back_to_fetch");

        step(6'h3F, 1'b1, F_RDY, 1'b0, "ill_fetch");
        step(6'h3F, 1'b0, B_SH,  1'b0, "ill_decode");
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        step(6'h3F, 1'b1, 18'h0, 1'b0, "ill_trap0");
        step(6'h00, 1'b1, 18'h0, 1'b0, "ill_trap1");
        check("ill_trap_flag", {17'd0, illegal_op}, 18'h1);
`else
        step(6'h3F, 1'b0, MR | B_4, 1'b0, "ill_nop_fetch");
`endif
        do_reset("reset_after_ill");

        // Reset in the middle of a load read must kill the instruction with no writeback.
        step(6'h23, 1'b0, 18'h0,        1'b0, "abort_reset");
        step(6'h23, 1'b1, F_RDY,        1'b0, "abort_fetch");
        step(6'h23, 1'b0, B_SH,         1'b0, "abort_decode");
        step(6'h23, 1'b0, SRCA | B_IMM, 1'b0, "abort_memadr");
        step(6'h23, 1'b0, IORD | MR,    1'b0, "abort_memrd_wait");
        mem_ready = 1'b1;
        do_reset("rst_mid_memrd");
        step(6'h23, 1'b1, 18'h0, 1'b0, "no_writeback_after_rst");

        // Random instruction stream against the step-queue model.
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        cur_op = 6'h00;
        thr = 7;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) thr = $urandom_range(1, 9);
            if (steps[0] == K_FETCH) begin
                if ($urandom_range(0, 7) == 0) cur_op = 6'($urandom);
                else cur_op = ops[$urandom_range(0, 5)];
            end
            rdy = ($urandom_range(0, 9) < thr);
            if (is_mem(steps[0]) && m_wait == MAXW) rdy = 1'b0;
            step(cur_op, rdy, 18'h0, 1'b1, "random");
            if (steps[0] == K_TRAP && $urandom_range(0, 3) == 0) do_reset("random_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
